// File: rtl/fuel_gauge.sv
// fuel_gauge: fuel bookkeeping downstream of the fuel/collision arbiter.
// Drains fuel on a frame-count schedule, refills on pickup pulses and
// subtracts a penalty on each accepted collision. It then drives the HUD
// fuel bar, the low-fuel warning and game over.
// Optional feature macro: FUEL_GAUGE_BLINK_EN (lowFuel blinks instead of steady).
module fuel_gauge #(
    parameter int unsigned FUEL_W       = 8,
    parameter int unsigned FUEL_MAX     = 200,
    parameter int unsigned REFILL       = 40,
    parameter int unsigned DRAIN_FRAMES = 15,
    parameter int unsigned PENALTY      = 20,
    parameter int unsigned GRACE_FRAMES = 60,
    parameter int unsigned LOW_THRESH   = 40
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              startOfFrame,
    input  logic              gameStart,
    input  logic              fuelPickup,
    input  logic              collision,
    output logic [FUEL_W-1:0] fuelLevel,
    output logic              fuelEmpty,
    output logic              lowFuel,
    output logic              penaltyPulse
);

    localparam int unsigned FRAME_W = (DRAIN_FRAMES > 1) ? $clog2(DRAIN_FRAMES) : 1;
    localparam int unsigned GRACE_W = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES) : 1;
    localparam int unsigned SUM_W   = FUEL_W + 2;

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(DRAIN_FRAMES - 1);
    localparam logic [GRACE_W-1:0] GRACE_LOAD = GRACE_W'(GRACE_FRAMES - 1);
    localparam logic [FUEL_W-1:0]  LEVEL_MAX  = FUEL_W'(FUEL_MAX);
    localparam logic [FUEL_W-1:0]  LEVEL_LOW  = FUEL_W'(LOW_THRESH);

    localparam logic signed [SUM_W-1:0] MAX_S     = SUM_W'(FUEL_MAX);
    localparam logic signed [SUM_W-1:0] REFILL_S  = SUM_W'(REFILL);
    localparam logic signed [SUM_W-1:0] PENALTY_S = SUM_W'(PENALTY);
    localparam logic signed [SUM_W-1:0] ONE_S     = SUM_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GRACE,
        EMPTY
    } state_t;

    state_t             state, state_nx;
    logic [FUEL_W-1:0]  level_nx;
    logic [FRAME_W-1:0] frame_cnt, frame_nx;
    logic [GRACE_W-1:0] grace_cnt, grace_nx;
    logic               empty_nx;
    logic               pen_nx;
    logic               coll_q;

    logic               active;
    logic               drain;
    logic               accepted;
    logic signed [SUM_W-1:0] lvl_ext;
    logic signed [SUM_W-1:0] sum;
    logic [FUEL_W-1:0]  clamped;
    logic               in_low;

    // State and datapath registers; everything returns to its idle/full values on reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            fuelLevel    <= LEVEL_MAX;
            frame_cnt    <= '0;
            grace_cnt    <= '0;
            fuelEmpty    <= 1'b0;
            penaltyPulse <= 1'b0;
            coll_q       <= 1'b0;
        end else begin
            state        <= state_nx;
            fuelLevel    <= level_nx;
            frame_cnt    <= frame_nx;
            grace_cnt    <= grace_nx;
            fuelEmpty    <= empty_nx;
            penaltyPulse <= pen_nx;
            coll_q       <= collision;
        end
    end

    // Next-state logic: drain/refill/penalty arithmetic, clamping and state transitions.
    always_comb begin
        state_nx = state;
        level_nx = fuelLevel;
        frame_nx = frame_cnt;
        grace_nx = grace_cnt;
        empty_nx = fuelEmpty;
        pen_nx   = 1'b0;
        drain    = 1'b0;
        accepted = 1'b0;
        lvl_ext  = '0;
        sum      = '0;
        clamped  = '0;

        active = (state == RUN) || (state == GRACE);

        // Frame counter wraps and drains one unit on the same cycle.
        if (active && startOfFrame) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_nx = '0;
                drain    = 1'b1;
            end else begin
                frame_nx = frame_cnt + 1'b1;
            end
        end

        // Only a fresh rising edge while fully vulnerable counts as a crash.
        accepted = (state == RUN) && collision && !coll_q;

        // Signed headroom lets the penalty go below zero before clamping.
        lvl_ext = signed'({2'b00, fuelLevel});
        sum     = lvl_ext
                + (fuelPickup ? REFILL_S  : '0)
                - (drain      ? ONE_S     : '0)
                - (accepted   ? PENALTY_S : '0);
        if (sum[SUM_W-1]) begin
            clamped = '0;
        end else if (sum > MAX_S) begin
            clamped = LEVEL_MAX;
        end else begin
            clamped = sum[FUEL_W-1:0];
        end

        case (state)
            IDLE, EMPTY: begin
                if (gameStart) begin
                    state_nx = RUN;
                    level_nx = LEVEL_MAX;
                    frame_nx = '0;
                    grace_nx = '0;
                    empty_nx = 1'b0;
                end
            end
            RUN, GRACE: begin
                if (gameStart) begin
                    state_nx = RUN;
                    level_nx = LEVEL_MAX;
                    frame_nx = '0;
                    grace_nx = '0;
                    empty_nx = 1'b0;
                end else begin
                    level_nx = clamped;
                    pen_nx   = accepted;
                    if (clamped == '0) begin
                        state_nx = EMPTY;
                        empty_nx = 1'b1;
                    end else if (accepted) begin
                        state_nx = GRACE;
                        grace_nx = GRACE_LOAD;
                    end else if (state == GRACE && startOfFrame) begin
                        if (grace_cnt == '0) begin
                            state_nx = RUN;
                        end else begin
                            grace_nx = grace_cnt - 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Low-fuel region is only meaningful while a run is in progress.
    always_comb begin
        in_low = ((state == RUN) || (state == GRACE))
              && (fuelLevel != '0)
              && (fuelLevel <= LEVEL_LOW);
    end

`ifdef FUEL_GAUGE_BLINK_EN
    logic       blink;
    logic [2:0] blink_cnt;

    // Blink phase: held visible outside the low region, toggles every 8th frame inside it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (!in_low) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (startOfFrame) begin
            blink_cnt <= blink_cnt + 1'b1;
            if (blink_cnt == 3'd7) begin
                blink <= ~blink;
            end
        end
    end

    // Warning is gated by the blink phase.
    always_comb begin
        lowFuel = in_low & blink;
    end
`else
    // Steady warning.
    always_comb begin
        lowFuel = in_low;
    end
`endif

endmodule
